ones_pattern_gen: RTL and testbench

- Inverse companion of the ones counter: given a requested ones count k, streams every WIDTH-bit word that has exactly k bits set.
- Words are emitted in ascending numeric order over a valid/ready handshake.
- Used as a stimulus/enumeration source feeding ones-count and parity datapaths. A popcount consumer downstream must report k for every emitted word.

---
 rtl/ones_pattern_gen_pkg.sv | 35 +++
 rtl/ones_pattern_gen_if.sv | 24 ++
 rtl/ones_pattern_gen_next.sv | 27 ++
 rtl/ones_pattern_gen.sv | 175 +++++++++++++++++
 tb/tb_ones_pattern_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ones_pattern_gen_pkg.sv
// Shared definitions for the ones-pattern generator: FSM encodings, default
// sizes, the low-ones mask builder and a popcount helper for the checker.
package opg_pkg;

    localparam int OPG_WIDTH = 8;
    localparam int OPG_CNT_W = 4;
    localparam int OPG_IDX_W = 8;
    // Helper functions work on this fixed width; callers slice down to WIDTH.
    localparam int OPG_MAX_W = 64;

    typedef logic [1:0] opg_state_t;

    localparam opg_state_t ST_IDLE = 2'd0;
    localparam opg_state_t ST_EMIT = 2'd1;
    localparam opg_state_t ST_FIN  = 2'd2;

    function automatic logic [OPG_MAX_W-1:0] opg_low_mask(input logic [7:0] k);
        logic [OPG_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < OPG_MAX_W; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    function automatic logic [7:0] opg_popcount(input logic [OPG_MAX_W-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < OPG_MAX_W; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// Pattern stream bundle: data word, its ordinal and the valid/ready pair.
interface ones_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8
);
    logic [WIDTH-1:0] dat_out;
    logic             dat_valid;
    logic             dat_ready;
    logic [IDX_W-1:0] word_idx;

    modport master (
        output dat_out,
        output dat_valid,
        output word_idx,
        input  dat_ready
    );

    modport slave (
        input  dat_out,
        input  dat_valid,
        input  word_idx,
        output dat_ready
    );
endinterface

// File: rtl/ones_pattern_gen_next.sv
// Combinational successor: next larger word with the same number of set bits,
// built from lowest-set-bit isolate, ripple add and a trailing-zero shift.
module opg_next_pattern #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] low_s;
    logic [WIDTH-1:0] ripple_s;
    logic [WIDTH-1:0] tail_s;
    logic [WIDTH-1:0] shifted_s;

    // low_s is one-hot, so OR-ing each masked candidate shift selects tail >> ctz
    always_comb begin
        low_s     = cur & (~cur + {{(WIDTH-1){1'b0}}, 1'b1});
        ripple_s  = cur + low_s;
        tail_s    = (ripple_s ^ cur) >> 2;
        shifted_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            shifted_s = shifted_s | ((tail_s >> i) & {WIDTH{low_s[i]}});
        end
        nxt = ripple_s | shifted_s;
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// Streams every WIDTH-bit word with exactly k ones in ascending order.
// Optional popcount self-check on each handshake: define ONES_PATTERN_CHECK_EN.
module ones_pattern_gen
    import opg_pkg::*;
#(
    parameter int WIDTH = OPG_WIDTH,
    parameter int CNT_W = OPG_CNT_W,
    parameter int IDX_W = OPG_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         count_in,
    input  logic                     abort,
    ones_pattern_gen_if.master       dat,
    output logic                     busy,
    output logic                     done,
    output logic                     bad_cnt,
    output logic                     chk_err
);

    localparam logic [CNT_W-1:0] WIDTH_K = CNT_W'(WIDTH);

    opg_state_t        state_q, state_d;
    logic [WIDTH-1:0]  cur_q, cur_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bad_q, bad_d;

    logic [WIDTH-1:0]     nxt_s;
    logic [WIDTH-1:0]     first_s;
    logic [WIDTH-1:0]     last_s;
    logic [OPG_MAX_W-1:0] low_full_s;
    logic [OPG_MAX_W-1:0] keep_full_s;
    logic                 k_bad_s;
    logic                 hs_s;

    opg_next_pattern #(.WIDTH(WIDTH)) u_next (
        .cur (cur_q),
        .nxt (nxt_s)
    );

    // First word has the k low bits set; last word has the k high bits set.
    always_comb begin
        k_bad_s     = (count_in > WIDTH_K);
        low_full_s  = opg_low_mask(8'(count_in));
        keep_full_s = opg_low_mask(8'(WIDTH_K - count_in));
        first_s     = low_full_s[WIDTH-1:0];
        last_s      = ~keep_full_s[WIDTH-1:0];
        hs_s        = valid_q & dat.dat_ready;
    end

    // Enumeration FSM; abort outranks a same-cycle handshake.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (k_bad_s) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        bad_d   = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                        cur_d   = first_s;
                        last_d  = last_s;
                        idx_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cur_d   = '0;
                    idx_d   = '0;
                end else if (hs_s) begin
                    if (cur_q == last_q) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        cur_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cur_d   = nxt_s;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cur_d   = '0;
                idx_d   = '0;
            end
        endcase
        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d == ST_EMIT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
        end
    end

`ifdef ONES_PATTERN_CHECK_EN
    logic [CNT_W-1:0] k_q, k_d;
    logic             chk_err_q, chk_err_d;
    logic [7:0]       pop_s;

    // Latch k at start and flag any handshaked word whose popcount differs.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            k_d = count_in;
        end else begin
            k_d = k_q;
        end
        pop_s     = opg_popcount(OPG_MAX_W'(cur_q));
        chk_err_d = chk_err_q | (hs_s & (pop_s != 8'(k_q)));
    end

    // Checker state; chk_err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= '0;
            chk_err_q <= 1'b0;
        end else begin
            k_q       <= k_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign dat.dat_out   = cur_q;
    assign dat.dat_valid = valid_q;
    assign dat.word_idx  = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bad_cnt       = bad_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: table of whole enumerations plus
// hand sequences for stalls, ignored start, abort and mid-stream reset.
module tb_ones_pattern_gen;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] count_in = '0;
    logic             busy, done, bad_cnt, chk_err;

    int n_chk = 0;
    int n_pass = 0;

    ones_pattern_gen_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) sif ();

    always #5 clk = ~clk;

    ones_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .count_in (count_in),
        .abort    (abort),
        .dat      (sif),
        .busy     (busy),
        .done     (done),
        .bad_cnt  (bad_cnt),
        .chk_err  (chk_err)
    );

    typedef struct {
        int         k;
        int         n;
        logic [7:0] first;
        logic [7:0] last;
        bit         bad;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int popc(input logic [7:0] w);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(w[i]);
        return c;
    endfunction

    // Brute-force successor: smallest larger word with the same popcount.
    function automatic logic [7:0] next_word(input logic [7:0] w, input int k);
        int v;
        v = int'(w) + 1;
        while (v < 256 && popc(8'(v)) != k) v++;
        return 8'(v);
    endfunction

    task automatic run_vec(input vec_t v);
        logic [7:0] exp_w, first_w, last_w;
        logic [7:0] last_idx;
        int n, busy_n;
        @(negedge clk);
        count_in = 4'(v.k);
        start = 1'b1;
        sif.dat_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.bad) begin
            chk("bad_valid", {31'd0, sif.dat_valid}, 32'd0);
            chk("bad_done", {31'd0, done}, 32'd1);
            chk("bad_flag", {31'd0, bad_cnt}, 32'd1);
            @(negedge clk);
            chk("bad_after", {28'd0, done, bad_cnt, busy, sif.dat_valid}, 32'd0);
        end else begin
            exp_w = v.first;
            first_w = sif.dat_out;
            last_w = 8'h00;
            last_idx = 8'h00;
            n = 0;
            busy_n = 0;
            while (sif.dat_valid && n < 300) begin
                chk($sformatf("word_k%0d_%0d", v.k, n), {16'd0, sif.word_idx, sif.dat_out},
                    {16'd0, 8'(n), exp_w});
                if (busy) busy_n++;
                last_w = sif.dat_out;
                last_idx = sif.word_idx;
                exp_w = next_word(exp_w, v.k);
                n++;
                @(negedge clk);
            end
            chk("first_word", {24'd0, first_w}, {24'd0, v.first});
            chk("last_word", {24'd0, last_w}, {24'd0, v.last});
            chk("last_idx", {24'd0, last_idx}, 32'(v.n - 1));
            chk("word_count", 32'(n), 32'(v.n));
            chk("busy_cycles", 32'(busy_n), 32'(v.n));
            chk("end_flags", {28'd0, done, bad_cnt, busy, sif.dat_valid}, 32'h8);
            @(negedge clk);
            chk("done_clr", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_w;
        int n, cyc;
        bit rdy;

        sif.dat_ready = 1'b0;
        vecs[0] = '{2, 28, 8'h03, 8'hC0, 1'b0};
        vecs[1] = '{0, 1, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{8, 1, 8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{9, 0, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{5, 56, 8'h1F, 8'hF8, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("reset_outs", {4'd0, chk_err, bad_cnt, done, busy, sif.dat_valid, sif.word_idx, sif.dat_out},
            32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // k=1 with ready pattern 1,0,0,1 and an ignored start mid-stream
        @(negedge clk);
        count_in = 4'd1;
        start = 1'b1;
        sif.dat_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        exp_w = 8'h01;
        n = 0;
        cyc = 0;
        while (n < 8 && cyc < 100) begin
            chk($sformatf("k1_word_c%0d", cyc), {15'd0, sif.dat_valid, sif.word_idx, sif.dat_out},
                {15'd0, 1'b1, 8'(n), exp_w});
            rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            sif.dat_ready = rdy;
            start = (cyc == 5);
            count_in = (cyc == 5) ? 4'd5 : 4'd1;
            @(negedge clk);
            if (rdy) begin
                n++;
                exp_w = exp_w << 1;
            end
            cyc++;
        end
        start = 1'b0;
        chk("k1_count", 32'(n), 32'd8);
        chk("k1_done", {30'd0, done, sif.dat_valid}, 32'h2);

        // k=4 abort at word_idx 10 together with ready
        @(negedge clk);
        count_in = 4'd4;
        start = 1'b1;
        sif.dat_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_w = 8'h0F;
        n = 0;
        while (n < 10 && sif.dat_valid) begin
            exp_w = next_word(exp_w, 4);
            n++;
            @(negedge clk);
        end
        chk("abort_pre", {16'd0, sif.word_idx, sif.dat_out}, {16'd0, 8'd10, exp_w});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outs", {12'd0, bad_cnt, done, busy, sif.dat_valid, sif.word_idx, sif.dat_out},
            32'd0);
        @(negedge clk);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        run_vec('{4, 70, 8'h0F, 8'hF0, 1'b0});
        chk("chk_err", {31'd0, chk_err}, 32'd0);

        // k=3 with asynchronous reset mid-stream
        @(negedge clk);
        count_in = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_pre", {16'd0, sif.word_idx, sif.dat_out}, {16'd0, 8'd4, 8'h13});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {4'd0, chk_err, bad_cnt, done, busy, sif.dat_valid, sif.word_idx, sif.dat_out},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_idle_%0d", i), {29'd0, done, busy, sif.dat_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
